hamming_serial_encoder: RTL and testbench

HAMMING_SERIAL_ENCODER -- requirements
Module: hamming_serial_encoder

---
 rtl/hamming_serial_encoder.sv | 162 ++++++++++++++++
 tb/tb_hamming_serial_encoder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_serial_encoder.sv
// rtl/hamming_serial_encoder.sv - serial-in / serial-out Hamming (SEC or SECDED) encoder
//
// Collects DATA_W serial data bits, builds the Hamming codeword in one cycle,
// then shifts it out one bit per accepted transfer.
//
// Ports:
//   clk          in   clock, all state on the rising edge
//   reset_n      in   synchronous active-low reset
//   write        in   data_inp valid
//   data_inp     in   serial data bit (taken when write && ready)
//   ready        out  encoder can take a data bit this cycle
//   out_ready    in   downstream takes data_outp this cycle
//   out_valid    out  data_outp carries a codeword bit
//   data_outp    out  serial codeword bit (0 when out_valid=0)
//   frame_start  out  first bit of a codeword (0 when out_valid=0)

module hamming_serial_encoder #(
    parameter int DATA_W   = 4,
    parameter int EXTENDED = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic write,
    input  logic data_inp,
    output logic ready,
    input  logic out_ready,
    output logic out_valid,
    output logic data_outp,
    output logic frame_start
);

    // Smallest R with 2^R >= DATA_W + R + 1
    function automatic int calc_par_w(input int dw);
        int r;
        r = 1;
        while ((1 << r) < (dw + r + 1)) r++;
        return r;
    endfunction

    localparam int PAR_W  = calc_par_w(DATA_W);
    localparam int N_W    = DATA_W + PAR_W;      // positions 1..N_W
    localparam int CODE_W = N_W + EXTENDED;
    localparam int CNT_W  = $clog2(CODE_W);

    if (DATA_W < 1 || DATA_W > 57 || EXTENDED < 0 || EXTENDED > 1) begin : g_bad_param
        $error("hamming_serial_encoder: DATA_W must be 1..57 and EXTENDED 0 or 1");
    end

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_ENCODE  = 2'd1,
        S_SHIFT   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_data;
    logic [CODE_W-1:0]   r_shift;
    logic [DATA_W:0]     w_data_cat;
    logic [N_W:1]        w_pos;
    logic [CODE_W-1:0]   w_code;
    logic                w_accept;
    logic                w_xfer;
    logic                w_last_in;
    logic                w_last_out;

    assign w_last_in  = (r_cnt == CNT_W'(DATA_W - 1));
    assign w_last_out = (r_cnt == CNT_W'(CODE_W - 1));

    // New bits enter at the top, so after DATA_W bits the first one sits at bit 0
    assign w_data_cat = {data_inp, r_data};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        ready       = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        w_xfer      = 1'b0;
        case (r_state)
            S_COLLECT: begin
                ready    = 1'b1;
                w_accept = write;
                if (write && w_last_in) w_next = S_ENCODE;
            end
            S_ENCODE: begin
                w_next = S_SHIFT;
            end
            S_SHIFT: begin
                out_valid = 1'b1;
                w_xfer    = out_ready;
                if (out_ready && w_last_out) w_next = S_COLLECT;
            end
            default: begin
                w_next = S_COLLECT;
            end
        endcase
        data_outp   = out_valid & r_shift[0];
        frame_start = out_valid & (r_cnt == '0);
    end

    // Codeword build: data fills non-power-of-two positions in order, then each
    // parity bit 2^i covers every position with bit i set. Parity positions are
    // still 0 when read, so the lower parity bits do not disturb higher ones.
    always_comb begin
        int   di;
        logic par;
        w_pos = '0;
        di    = 0;
        for (int p = 1; p <= N_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                w_pos[p] = r_data[di];
                di++;
            end
        end
        for (int i = 0; i < PAR_W; i++) begin
            par = 1'b0;
            for (int p = 1; p <= N_W; p++) begin
                if (((p >> i) & 1) != 0) par = par ^ w_pos[p];
            end
            w_pos[1 << i] = par;
        end
    end

    // Shift register index 0 is the first bit on the wire
    if (EXTENDED != 0) begin : g_ext
        logic w_par_all;
        assign w_par_all = ^w_pos;
        assign w_code    = {w_pos, w_par_all};
    end else begin : g_sec
        assign w_code = w_pos;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_data  <= '0;
            r_shift <= '0;
        end else begin
            if (w_accept) begin
                r_data <= w_data_cat[DATA_W:1];
                r_cnt  <= w_last_in ? '0 : r_cnt + 1'b1;
            end
            if (r_state == S_ENCODE) begin
                r_shift <= w_code;
            end
            if (w_xfer) begin
                r_shift <= r_shift >> 1;
                r_cnt   <= w_last_out ? '0 : r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hamming_serial_encoder.sv
// tb/tb_hamming_serial_encoder.sv - directed self-checking bench for hamming_serial_encoder

module tb_hamming_serial_encoder;

    logic clk = 1'b0;
    logic reset_n;
    logic wr[3];
    logic din[3];
    logic ordy[3];
    logic rdy[3];
    logic ov[3];
    logic dout[3];
    logic fs[3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // instance 0: DATA_W=4 SEC, 1: DATA_W=4 SECDED, 2: DATA_W=11 SECDED
    hamming_serial_encoder #(.DATA_W(4), .EXTENDED(0)) u_sec4 (
        .clk(clk), .reset_n(reset_n), .write(wr[0]), .data_inp(din[0]), .ready(rdy[0]),
        .out_ready(ordy[0]), .out_valid(ov[0]), .data_outp(dout[0]), .frame_start(fs[0]));
    hamming_serial_encoder #(.DATA_W(4), .EXTENDED(1)) u_ded4 (
        .clk(clk), .reset_n(reset_n), .write(wr[1]), .data_inp(din[1]), .ready(rdy[1]),
        .out_ready(ordy[1]), .out_valid(ov[1]), .data_outp(dout[1]), .frame_start(fs[1]));
    hamming_serial_encoder #(.DATA_W(11), .EXTENDED(1)) u_ded11 (
        .clk(clk), .reset_n(reset_n), .write(wr[2]), .data_inp(din[2]), .ready(rdy[2]),
        .out_ready(ordy[2]), .out_valid(ov[2]), .data_outp(dout[2]), .frame_start(fs[2]));

    // Reference: parity bits are the bits of the XOR of the indices of all set data positions
    function automatic logic [63:0] ref_code(input logic [63:0] d, input int dw, input int ext);
        int pw, n, syn, di;
        logic [63:0] pos;
        pw = 0;
        while ((1 << pw) < dw + pw + 1) pw++;
        n = dw + pw; pos = '0; syn = 0; di = 0;
        for (int p = 1; p <= n; p++) begin
            if ((p & (p - 1)) != 0) begin
                pos[p] = d[di];
                if (d[di]) syn = syn ^ p;
                di++;
            end
        end
        for (int i = 0; i < pw; i++) pos[1 << i] = syn[i];
        if (ext != 0) begin
            pos[0] = ^pos;
            return pos;
        end
        return pos >> 1;
    endfunction

    task automatic send_word(input int s, input logic [63:0] d, input int n, input int gap_max,
                             output int miss);
        int g;
        miss = 0;
        for (int i = 0; i < n; i++) begin
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            for (int j = 0; j < g; j++) begin
                @(negedge clk);
                wr[s]  = 1'b0;
                din[s] = 1'($urandom_range(1, 0));
            end
            @(negedge clk);
            wr[s]  = 1'b1;
            din[s] = d[i];
            if (rdy[s] !== 1'b1) miss++;
        end
        @(negedge clk);
        wr[s] = 1'b0;
    endtask

    // Starts at the negedge of the encode cycle; lat counts cycles from there (encode = 1)
    task automatic collect_word(input int s, input int code_w, input bit stall, input bit wpulse,
                                output logic [63:0] bits, output logic [63:0] fsv, output int got,
                                output int lat, output int nov, output int holdbad, output int zerobad);
        bit   pst;
        logic pd, pf;
        int   k;
        bits = '0; fsv = '0; got = 0; lat = 0; nov = 0; holdbad = 0; zerobad = 0;
        pst = 1'b0; pd = 1'b0; pf = 1'b0; k = 1;
        while (got < code_w && k < 300) begin
            ordy[s] = stall ? 1'($urandom_range(1, 0)) : 1'b1;
            if (wpulse) begin
                wr[s]  = 1'($urandom_range(1, 0));
                din[s] = 1'($urandom_range(1, 0));
            end
            if (ov[s] === 1'b1) begin
                nov++;
                if (lat == 0) lat = k;
                if (pst && (dout[s] !== pd || fs[s] !== pf)) holdbad++;
                pst = !ordy[s]; pd = dout[s]; pf = fs[s];
                if (ordy[s]) begin
                    bits[got] = dout[s];
                    fsv[got]  = fs[s];
                    got++;
                end
            end else begin
                if (pst) holdbad++;
                if (dout[s] !== 1'b0 || fs[s] !== 1'b0) zerobad++;
                pst = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        wr[s]   = 1'b0;
        ordy[s] = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        for (int s = 0; s < 3; s++) begin wr[s] = 1'b0; din[s] = 1'b0; ordy[s] = 1'b1; end
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if ({rdy[s], ov[s], dout[s], fs[s]} !== 4'b1000) begin
                failures++;
                $display("FAIL reset_state inst=%0d got rdy/ov/dout/fs=%b exp=1000", s,
                         {rdy[s], ov[s], dout[s], fs[s]});
            end
        end
        reset_n = 1'b1;
    endtask

    task automatic test_word(input string name, input int s, input logic [63:0] d, input int dw,
                             input int code_w, input logic [63:0] exp, input int gap_max,
                             input bit stall, input bit wpulse);
        logic [63:0] b, f;
        int got, lat, nov, hb, zb, miss;
        send_word(s, d, dw, gap_max, miss);
        collect_word(s, code_w, stall, wpulse, b, f, got, lat, nov, hb, zb);
        checks++;
        if (b !== exp || got !== code_w) begin
            failures++;
            $display("FAIL %s bits got=%0h (%0d bits) exp=%0h (%0d bits)", name, b, got, exp, code_w);
        end
        checks++;
        if (f !== 64'h1) begin
            failures++;
            $display("FAIL %s frame_start got=%0h exp=1", name, f);
        end
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("FAIL %s latency got=%0d exp=2", name, lat);
        end
        checks++;
        if (hb !== 0 || zb !== 0 || miss !== 0) begin
            failures++;
            $display("FAIL %s hold/zero/ready got=%0d/%0d/%0d exp=0/0/0", name, hb, zb, miss);
        end
        if (!stall) begin
            checks++;
            if (nov !== code_w) begin
                failures++;
                $display("FAIL %s valid_cycles got=%0d exp=%0d", name, nov, code_w);
            end
        end
        checks++;
        if (rdy[s] !== 1'b1 || ov[s] !== 1'b0) begin
            failures++;
            $display("FAIL %s back_to_collect got rdy=%b ov=%b exp rdy=1 ov=0", name, rdy[s], ov[s]);
        end
    endtask

    task automatic test_sec_basic;
        test_word("sec_1011", 0, 64'b1101, 4, 7, 64'b1100110, 0, 1'b0, 1'b0);
        test_word("sec_1111", 0, 64'b1111, 4, 7, 64'b1111111, 0, 1'b0, 1'b0);
    endtask

    task automatic test_secded_basic;
        test_word("ded_1011", 1, 64'b1101, 4, 8, 64'b11001100, 0, 1'b0, 1'b0);
        test_word("ded_1111", 1, 64'b1111, 4, 8, 64'hFF, 0, 1'b0, 1'b0);
    endtask

    task automatic test_gaps;
        test_word("gap_1011", 0, 64'b1101, 4, 7, 64'b1100110, 3, 1'b0, 1'b0);
        test_word("gap_0110", 0, 64'b0110, 4, 7, 64'b0110011, 3, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure;
        test_word("bp_1011", 1, 64'b1101, 4, 8, 64'b11001100, 0, 1'b1, 1'b1);
        test_word("bp_1111", 1, 64'b1111, 4, 8, 64'hFF, 1, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back;
        test_word("b2b_0011", 0, 64'b0011, 4, 7, 64'b0011110, 0, 1'b0, 1'b0);
        test_word("b2b_1011", 0, 64'b1101, 4, 7, 64'b1100110, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random_11;
        logic [63:0] d, exp, b, f;
        int got, lat, nov, hb, zb, miss, syn;
        for (int w = 0; w < 16; w++) begin
            d   = 64'($urandom) & 64'h7FF;
            exp = ref_code(d, 11, 1);
            send_word(2, d, 11, 2, miss);
            collect_word(2, 16, 1'b1, 1'b0, b, f, got, lat, nov, hb, zb);
            checks++;
            if (b !== exp || hb !== 0 || miss !== 0) begin
                failures++;
                $display("FAIL rand11 word=%0h got=%0h exp=%0h hold=%0d miss=%0d", d, b, exp, hb, miss);
            end
            syn = 0;
            for (int p = 1; p < 16; p++) if (b[p]) syn = syn ^ p;
            checks++;
            if (syn !== 0 || (^b[15:0]) !== 1'b0) begin
                failures++;
                $display("FAIL rand11_decode word=%0h syndrome=%0d parity=%b exp 0/0", d, syn, ^b[15:0]);
            end
        end
    endtask

    task automatic test_reset_mid_collect;
        @(negedge clk); wr[0] = 1'b1; din[0] = 1'b1;
        @(negedge clk); din[0] = 1'b0;
        @(negedge clk); wr[0] = 1'b0; reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({rdy[0], ov[0], dout[0], fs[0]} !== 4'b1000) begin
            failures++;
            $display("FAIL rst_collect_state got=%b exp=1000", {rdy[0], ov[0], dout[0], fs[0]});
        end
        reset_n = 1'b1;
        test_word("rst_collect_next", 0, 64'b0110, 4, 7, 64'b0110011, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_shift;
        int miss, w;
        send_word(0, 64'b1101, 4, 0, miss);
        w = 0;
        while (ov[0] !== 1'b1 && w < 10) begin @(negedge clk); w++; end
        repeat (2) @(negedge clk);
        checks++;
        if (ov[0] !== 1'b1 || dout[0] !== 1'b1) begin
            failures++;
            $display("FAIL rst_shift_third_bit got ov=%b dout=%b exp 1/1", ov[0], dout[0]);
        end
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({rdy[0], ov[0], dout[0], fs[0]} !== 4'b1000) begin
            failures++;
            $display("FAIL rst_shift_state got=%b exp=1000", {rdy[0], ov[0], dout[0], fs[0]});
        end
        reset_n = 1'b1;
        test_word("rst_shift_next", 0, 64'b0011, 4, 7, 64'b0011110, 0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_sec_basic();
        test_secded_basic();
        test_gaps();
        test_backpressure();
        test_back_to_back();
        test_random_11();
        test_reset_mid_collect();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
